// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with synchronous sanitising load,
// sticky-until-next-load invalid-digit flag and combinational terminal count.
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   out,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0][3:0] digits_q, digits_d;
  logic                   load_err_q, load_err_d;
  logic                   all_nines, all_zeros;
  logic                   carry;

  always_comb begin
    all_nines = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_q[i] != 4'd9) all_nines = 1'b0;
      if (digits_q[i] != 4'd0) all_zeros = 1'b0;
    end
  end

  // tc feeds the next stage's enable, so it must not wait for a clock edge.
  assign tc = enable & ~load & ((up_down & all_nines) | (~up_down & all_zeros));

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    digits_d   = digits_q;
    load_err_d = load_err_q;
    carry      = 1'b0;
    if (load) begin
      load_err_d = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        if (load_value[4*i +: 4] > 4'd9) begin
          digits_d[i] = 4'd0;
          load_err_d  = 1'b1;
        end else begin
          digits_d[i] = load_value[4*i +: 4];
        end
      end
    end else if (enable) begin
      // carry means "all lower digits are at their wrap value", so this digit steps
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (up_down) begin
            if (digits_q[i] == 4'd9) begin
              digits_d[i] = 4'd0;
            end else begin
              digits_d[i] = digits_q[i] + 4'd1;
              carry       = 1'b0;
            end
          end else begin
            if (digits_q[i] == 4'd0) begin
              digits_d[i] = 4'd9;
            end else begin
              digits_d[i] = digits_q[i] - 4'd1;
              carry       = 1'b0;
            end
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q   <= '0;
      load_err_q <= 1'b0;
    end else begin
      digits_q   <= digits_d;
      load_err_q <= load_err_d;
    end
  end

  assign out      = digits_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: directed scenarios then random traffic,
// compared against an integer (decimal arithmetic) reference model.
module tb_bcd_updown_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MOD    = 10000;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         up_down;
  logic         load;
  logic [W-1:0] load_value;
  logic [W-1:0] out;
  logic         tc;
  logic         load_err;

  int checks = 0;
  int errors = 0;
  int mv     = 0;
  bit merr   = 1'b0;

  bcd_updown_counter #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .out        (out),
    .tc         (tc),
    .load_err   (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    p = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(p % 10);
      p = p / 10;
    end
    return r;
  endfunction

  function automatic int load_decimal(input logic [W-1:0] lv);
    int v, p, d;
    v = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v + d * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic bit bad_digit(input logic [W-1:0] lv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven; check tc before the edge, advance model, check state after.
  task automatic cycle(input string tag);
    bit exp_tc;
    #1;
    exp_tc = enable && !load && (up_down ? (mv == MOD - 1) : (mv == 0));
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, exp_tc});
    @(posedge clk);
    if (reset) begin
      mv = 0;
      merr = 1'b0;
    end else if (load) begin
      mv = load_decimal(load_value);
      merr = bad_digit(load_value);
    end else if (enable) begin
      mv = up_down ? (mv + 1) % MOD : (mv + MOD - 1) % MOD;
    end
    #1;
    check({tag, ".out"}, {16'd0, out}, {16'd0, to_bcd(mv)});
    check({tag, ".err"}, {31'd0, load_err}, {31'd0, merr});
  endtask

  task automatic set_in(input bit r, input bit ld, input logic [W-1:0] lv,
                        input bit en, input bit ud);
    reset      = r;
    load       = ld;
    load_value = lv;
    enable     = en;
    up_down    = ud;
  endtask

  initial begin
    // 1. reset, then count up ten steps
    set_in(1'b1, 1'b0, '0, 1'b0, 1'b1);
    #2;
    check("rst.out_async", {16'd0, out}, 32'h0);
    check("rst.err_async", {31'd0, load_err}, 32'h0);
    repeat (2) cycle("rst");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1);
    repeat (10) cycle("up10");
    check("up10.literal", {16'd0, out}, 32'h0010);

    // 2. up wrap and tc
    set_in(1'b0, 1'b1, 16'h9998, 1'b1, 1'b1);
    cycle("ld9998");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle("to9999");
    check("to9999.literal", {16'd0, out}, 32'h9999);
    cycle("wrap_up");
    check("wrap_up.literal", {16'd0, out}, 32'h0000);

    // 3. down with borrow and wrap
    set_in(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    cycle("ld0100");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("dn1");
    check("dn1.literal", {16'd0, out}, 32'h0099);
    cycle("dn2");
    set_in(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    cycle("ld0000");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle("wrap_dn");
    check("wrap_dn.literal", {16'd0, out}, 32'h9999);

    // 4. invalid-digit load, then a clean load clears the flag
    set_in(1'b0, 1'b1, 16'h12A7, 1'b0, 1'b1);
    cycle("ld_bad");
    check("ld_bad.literal", {16'd0, out}, 32'h1207);
    set_in(1'b0, 1'b1, 16'h0042, 1'b0, 1'b1);
    cycle("ld_good");

    // 5. load beats enable at a wrap boundary, then hold
    set_in(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    cycle("ld9999");
    set_in(1'b0, 1'b1, 16'h3141, 1'b1, 1'b1);
    cycle("ld_prio");
    set_in(1'b0, 1'b0, 16'h7777, 1'b0, 1'b0);
    repeat (5) cycle("hold");

    // 6. async reset mid-count, with load_err previously set
    set_in(1'b0, 1'b1, 16'hF572, 1'b0, 1'b1);
    cycle("ld_f572");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle("to0573");
    check("to0573.literal", {16'd0, out}, 32'h0573);
    #3;
    reset = 1'b1;
    #1;
    mv = 0;
    merr = 1'b0;
    check("async_rst.out", {16'd0, out}, {16'd0, to_bcd(mv)});
    check("async_rst.err", {31'd0, load_err}, 32'h0);
    set_in(1'b1, 1'b1, 16'h5555, 1'b1, 1'b1);
    cycle("rst_hold");
    set_in(1'b0, 1'b0, '0, 1'b1, 1'b1);
    cycle("resume");
    check("resume.literal", {16'd0, out}, 32'h0001);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] lv;
      case ($urandom_range(0, 5))
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        2: lv = 16'h9998;
        3: lv = 16'h0001;
        default: lv = W'($urandom);
      endcase
      set_in(1'b0, ($urandom_range(0, 7) == 0), lv,
             ($urandom_range(0, 3) != 0), 1'($urandom));
      cycle("rand");
      for (int i = 0; i < DIGITS; i++)
        if (out[4*i +: 4] > 4'd9)
          check("rand.digit_range", {28'd0, out[4*i +: 4]}, 32'd9);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter; successor to the single-digit mod-10 counter.
- Adds the following over the single-digit counter:
  - DIGITS-wide cascaded decades.
  - Up/down mode.
  - Synchronous parallel load, with invalid-digit detection.
  - Terminal-count output for cascading further counter stages.
- Used for decimal event/time tallies feeding display drivers.

Parameters:
DIGITS, 4, number of BCD decades; legal range 1..8; out width = 4*DIGITS

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count enable; 1 = step count this cycle
up_down  input  1  direction; 1 = count up, 0 = count down
load  input  1  synchronous load strobe; has priority over enable
load_value  input  4*DIGITS  BCD value to load; digit i = bits [4i+3:4i], digit 0 = least significant
out  output  4*DIGITS  current count, packed BCD, digit 0 in bits [3:0]
tc  output  1  terminal count, combinational: next enabled step wraps
load_err  output  1  registered flag: last load contained a non-BCD digit

Behaviour:

Reset:
- reset=1 asynchronously forces out=0 and load_err=0.
- This holds while reset is high, regardless of clk, load or enable.
- The first count occurs on the first rising clk edge after reset deasserts.

Priority per rising edge: load > enable > hold.

Load (load=1):
- Each digit is captured from load_value.
- Any digit value 10..15 is replaced by 0 in out.
- load_err is set to 1 if any digit was 10..15, else cleared to 0.
- No count step occurs that cycle, regardless of enable.

Count up (load=0, enable=1, up_down=1):
- Digit 0 increments: 9 -> 0, else +1.
- Digit i (i>0) steps only when digits 0..i-1 are all 9.
- All-9s wraps to all-0s in one cycle, e.g. DIGITS=4: 9999 -> 0000.

Count down (load=0, enable=1, up_down=0):
- Digit 0 decrements: 0 -> 9, else -1.
- Digit i steps only when digits 0..i-1 are all 0.
- All-0s wraps to all-9s, e.g. 0000 -> 9999.

Hold:
- enable=0 and load=0: out is unchanged.
- load_err is changed only by a load or by reset.

tc:
- tc = enable & !load & ((up_down & out==all 9s) | (!up_down & out==all 0s)).
- Combinational, with no latency; it is high exactly in the cycle before a wrap.
- Intended to drive the enable of the next stage.

Direction change:
- up_down may change on any cycle and takes effect at the next edge.
- There is no pipeline or history state.

Latency:
- out updates at the edge where load or enable is sampled; one cycle, registered.

Invalid internal state:
- Unreachable by construction: load sanitises input, and reset produces a legal value.
- A digit value above 9 must never appear on out.

Reset mid-operation:
- Asserting reset during load or counting aborts immediately; out=0.
- No partial ripple is visible.

Simultaneous load and enable with out at a wrap boundary:
- load wins; tc=0 that cycle.

Test Plan:
1. Reset then count up: reset=1 for 2 edges, release, enable=1, up_down=1, 10 edges -> out=0000 during reset, then 0001..0010 (BCD 0x0010 after 10 edges), tc=0 throughout.
2. Up wrap and tc: load 9998, enable=1, up_down=1 -> next edge 9999 with tc=1 in that cycle; following edge 0000 with tc=0.
3. Down with borrow and wrap: load 0100, up_down=0, 2 edges -> 0099, 0098; load 0000 -> tc=1, next edge 9999.
4. Invalid load: load_value=0x12A7 -> out=0x1207, load_err=1; then load 0x0042 -> out=0x0042, load_err=0.
5. Priority and hold:
   - load=1 with enable=1 at out=9999 -> out=load_value, tc=0.
   - enable=0 for 5 edges -> out unchanged.
6. Async reset mid-count: assert reset between clock edges while counting at 0573 -> out=0000 immediately (before the next edge); load_err=0; counting resumes from 0001 after release.
